// File: rtl/h264intra8x8cc_pkg.sv
// h264intra8x8cc_pkg: shared constants and read-address layout for the intra 8x8 chroma path
package h264intra8x8cc_pkg;
  localparam int CC_WORDS = 32;
  localparam int CC_ADDR_W = 5;
  typedef struct packed {
    logic       crcb;
    logic [2:0] row;
    logic       half;
  } cc_addr_t;
endpackage

// File: rtl/h264intra8x8cc_inbuf_if.sv
// h264intra8x8cc_inbuf_if: write/read handshake bundle of the chroma ping-pong input buffer
interface h264intra8x8cc_inbuf_if #(parameter int PIXW = 8);
  logic              STROBEI;
  logic [4*PIXW-1:0] DATAI;
  logic              READYI;
  logic [4:0]        ISTATE;
  logic              OVERRUN;
  logic              MBVALID;
  logic              RDEN;
  logic              RDCRCB;
  logic [2:0]        RDROW;
  logic              RDHALF;
  logic [4*PIXW-1:0] DATAO;
  logic              RDVALID;
  logic              RELEASE;
  modport master(output STROBEI, DATAI, RDEN, RDCRCB, RDROW, RDHALF, RELEASE,
                 input READYI, ISTATE, OVERRUN, MBVALID, DATAO, RDVALID);
  modport slave(input STROBEI, DATAI, RDEN, RDCRCB, RDROW, RDHALF, RELEASE,
                output READYI, ISTATE, OVERRUN, MBVALID, DATAO, RDVALID);
endinterface

// File: rtl/h264intra8x8cc_bufram.sv
// h264intra8x8cc_bufram: 64-word simple dual-port RAM with registered, resettable read port
module h264intra8x8cc_bufram #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [5:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [5:0]   raddr,
  output logic [W-1:0] q
);
  logic [W-1:0] mem [64];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/h264intra8x8cc_inbuf.sv
// h264intra8x8cc_inbuf: ping-pong chroma macroblock buffer, raster writes in, component/row/half reads out
module h264intra8x8cc_inbuf
  import h264intra8x8cc_pkg::*;
#(parameter int PIXW = 8) (
  input logic CLK2,
  input logic NEWLINE,
  h264intra8x8cc_inbuf_if.slave bus
);
  logic                 wbank, rbank, overrun, rdvalid, acc, last, rd, rel;
  logic [CC_ADDR_W-1:0] wcnt;
  logic [1:0]           full, full_n;
  cc_addr_t             ra;
  always_comb begin
    acc = bus.STROBEI && !full[wbank];
    last = acc && wcnt == CC_ADDR_W'(CC_WORDS - 1);
    rd = bus.RDEN && full[rbank];
    rel = bus.RELEASE && full[rbank];
    ra = '{crcb: bus.RDCRCB, row: bus.RDROW, half: bus.RDHALF};
    full_n = full;
    if (last) full_n[wbank] = 1'b1;
    if (rel) full_n[rbank] = 1'b0;
  end
  // a full read bank always differs from wbank, so set and clear never collide
  always_ff @(posedge CLK2) begin
    if (NEWLINE) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt <= '0;
      full <= '0;
      overrun <= 1'b0;
      rdvalid <= 1'b0;
    end else begin
      wcnt <= acc ? wcnt + 1'b1 : wcnt;
      wbank <= wbank ^ last;
      rbank <= rbank ^ rel;
      full <= full_n;
      overrun <= overrun | (bus.STROBEI & full[wbank]);
      rdvalid <= rd;
    end
  end
  h264intra8x8cc_bufram #(.W(4*PIXW)) u_ram (
    .clk(CLK2),
    .rst(NEWLINE),
    .we(acc && !NEWLINE),
    .waddr({wbank, wcnt}),
    .wdata(bus.DATAI),
    .re(rd),
    .raddr({rbank, ra}),
    .q(bus.DATAO)
  );
  assign bus.READYI = !full[wbank];
  assign bus.ISTATE = wcnt;
  assign bus.OVERRUN = overrun;
  assign bus.MBVALID = full[rbank];
  assign bus.RDVALID = rdvalid;
endmodule

// File: tb/tb_h264intra8x8cc_inbuf.sv
// tb_h264intra8x8cc_inbuf: directed stimulus with an expected-read-data queue drained by a monitor
module tb_h264intra8x8cc_inbuf;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, fails = 0, m_checks = 0, m_fails = 0;
  logic [31:0] expq[$];
  h264intra8x8cc_inbuf_if #(.PIXW(8)) bus ();
  h264intra8x8cc_inbuf #(.PIXW(8)) dut (.CLK2(clk), .NEWLINE(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wr(input logic [31:0] v);
    bus.STROBEI = 1'b1;
    bus.DATAI = v;
    step();
    bus.STROBEI = 1'b0;
  endtask
  task automatic rdq(input logic c, input logic [2:0] r, input logic h, input logic [31:0] exp);
    bus.RDEN = 1'b1;
    bus.RDCRCB = c;
    bus.RDROW = r;
    bus.RDHALF = h;
    expq.push_back(exp);
    step();
    bus.RDEN = 1'b0;
    step();
  endtask
  task automatic reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.RDVALID) begin
      m_checks++;
      if (expq.size() == 0) begin
        m_fails++;
        $display("FAIL rd_unexpected: got data %0d expected no RDVALID", bus.DATAO);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        if (bus.DATAO !== e) begin
          m_fails++;
          $display("FAIL rd_data: got %0d expected %0d", bus.DATAO, e);
        end
      end
    end
  end
  initial begin
    bus.STROBEI = 1'b0;
    bus.DATAI = '0;
    bus.RDEN = 1'b0;
    bus.RDCRCB = 1'b0;
    bus.RDROW = '0;
    bus.RDHALF = 1'b0;
    bus.RELEASE = 1'b0;
    step();
    reset();
    chk("rst_readyi", bus.READYI, 1);
    chk("rst_istate", bus.ISTATE, 0);
    chk("rst_mbvalid", bus.MBVALID, 0);
    chk("rst_overrun", bus.OVERRUN, 0);
    chk("rst_rdvalid", bus.RDVALID, 0);
    chk("rst_datao", bus.DATAO, 0);
    for (int i = 0; i < 32; i++) begin
      chk("fill_istate", bus.ISTATE, i);
      wr(i);
    end
    chk("mb1_istate", bus.ISTATE, 0);
    chk("mb1_mbvalid", bus.MBVALID, 1);
    chk("mb1_readyi", bus.READYI, 1);
    rdq(1'b1, 3'd7, 1'b1, 31);
    rdq(1'b0, 3'd2, 1'b1, 5);
    for (int i = 32; i < 64; i++) wr(i);
    chk("pp_readyi", bus.READYI, 0);
    chk("pp_mbvalid", bus.MBVALID, 1);
    chk("pp_istate", bus.ISTATE, 0);
    wr(99);
    chk("ovr_flag", bus.OVERRUN, 1);
    chk("ovr_istate", bus.ISTATE, 0);
    rdq(1'b0, 3'd0, 1'b0, 0);
    bus.RELEASE = 1'b1;
    step();
    bus.RELEASE = 1'b0;
    chk("rel_readyi", bus.READYI, 1);
    chk("rel_mbvalid", bus.MBVALID, 1);
    chk("rel_overrun_sticky", bus.OVERRUN, 1);
    rdq(1'b0, 3'd0, 1'b0, 32);
    rdq(1'b1, 3'd7, 1'b1, 63);
    rdq(1'b1, 3'd0, 1'b0, 48);
    reset();
    chk("rst2_overrun", bus.OVERRUN, 0);
    for (int i = 0; i < 32; i++) wr(100 + i);
    for (int i = 0; i < 31; i++) wr(200 + i);
    bus.STROBEI = 1'b1;
    bus.DATAI = 231;
    bus.RELEASE = 1'b1;
    bus.RDEN = 1'b1;
    bus.RDCRCB = 1'b0;
    bus.RDROW = 3'd0;
    bus.RDHALF = 1'b0;
    expq.push_back(100);
    step();
    bus.STROBEI = 1'b0;
    bus.RELEASE = 1'b0;
    bus.RDEN = 1'b0;
    chk("sim_mbvalid", bus.MBVALID, 1);
    chk("sim_readyi", bus.READYI, 1);
    chk("sim_istate", bus.ISTATE, 0);
    step();
    rdq(1'b1, 3'd7, 1'b1, 231);
    reset();
    for (int i = 0; i < 10; i++) wr(300 + i);
    chk("mid_istate", bus.ISTATE, 10);
    reset();
    chk("mid_rst_istate", bus.ISTATE, 0);
    chk("mid_rst_mbvalid", bus.MBVALID, 0);
    chk("mid_rst_readyi", bus.READYI, 1);
    bus.RDEN = 1'b1;
    step();
    bus.RDEN = 1'b0;
    chk("idle_rdvalid", bus.RDVALID, 0);
    chk("idle_datao", bus.DATAO, 0);
    bus.RELEASE = 1'b1;
    step();
    bus.RELEASE = 1'b0;
    chk("idle_rel_mbvalid", bus.MBVALID, 0);
    chk("idle_rel_readyi", bus.READYI, 1);
    chk("idle_rel_istate", bus.ISTATE, 0);
    for (int i = 0; i < 32; i++) wr(400 + i);
    chk("fresh_mbvalid", bus.MBVALID, 1);
    rdq(1'b0, 3'd3, 1'b0, 406);
    rdq(1'b1, 3'd5, 1'b1, 427);
    step();
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks + m_checks, fails + m_fails);
    $finish;
  end
endmodule
